// File: rtl/cnt_run_fsm_pkg.sv
// Shared definitions for the counter run-control FSM: state encoding and
// default run-length width.
package cnt_run_fsm_pkg;

  localparam int CNT_WIDTH_DEF = 7;

  // 2'd3 is unused; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cnt_run_remain.sv
// Loadable down-counter tracking how many enables are still owed in a run;
// flags the final enable so the FSM can move to DONE on that edge.
module cnt_run_remain
  import cnt_run_fsm_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic                 last
);

  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ZERO = '0;

  logic [CNT_WIDTH-1:0] remain_r;

  // Load wins over decrement; the zero guard keeps the count from wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain_r <= ZERO;
    end else if (load) begin
      remain_r <= load_val;
    end else if (dec && (remain_r != ZERO)) begin
      remain_r <= remain_r - ONE;
    end
  end

  assign last = (remain_r == ONE);

endmodule

// File: rtl/cnt_run_fsm.sv
// Run-control FSM driving a Counter's en/done: N enabled cycles, stall-aware,
// then a one-cycle done pulse. Optional sticky err_o under CNT_RUN_FSM_ERR_EN.
module cnt_run_fsm
  import cnt_run_fsm_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] num_cnt_i,
  input  logic                 stall_i,
  output logic                 en_o,
  output logic                 done_o,
  output logic                 idle_o
`ifdef CNT_RUN_FSM_ERR_EN
  ,
  output logic                 err_o
`endif
);

  state_t state, state_nxt;
  logic   accept;
  logic   en;
  logic   last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    en        = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          accept    = 1'b1;
          state_nxt = (num_cnt_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        en = !stall_i;
        if (en && last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign en_o   = en;
  assign done_o = (state == ST_DONE);
  assign idle_o = (state == ST_IDLE);

  cnt_run_remain #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_remain (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .load_val(num_cnt_i),
    .dec     (en),
    .last    (last)
  );

`ifdef CNT_RUN_FSM_ERR_EN
  // Sticky until the next accepted start; a start while busy never queues.
  logic err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (start_i && (state != ST_IDLE)) begin
      err_r <= 1'b1;
    end else if (accept) begin
      err_r <= 1'b0;
    end
  end

  assign err_o = err_r;
`endif

endmodule

// File: tb/tb_cnt_run_fsm.sv
// Randomized scoreboard bench for cnt_run_fsm: stimulus predicts each run's
// enable count and start-to-done latency, a negedge monitor checks every done.
module tb_cnt_run_fsm;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [W-1:0] num_cnt_i = '0;
  logic         stall_i = 1'b0;
  logic         en_o, done_o, idle_o;
`ifdef CNT_RUN_FSM_ERR_EN
  logic         err_o;
  logic         err_exp = 1'b0;
`endif

  cnt_run_fsm #(.CNT_WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .num_cnt_i(num_cnt_i),
    .stall_i  (stall_i),
    .en_o     (en_o),
    .done_o   (done_o),
    .idle_o   (idle_o)
`ifdef CNT_RUN_FSM_ERR_EN
    ,
    .err_o    (err_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int n;
    int lat;
    int s;
  } exp_t;

  exp_t q[$];
  bit   pat[512];

  // Monitor: a done pulse closes one run; enables since the last run are counted.
  int en_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      en_cnt = 0;
    end else begin
      if (en_o) en_cnt++;
      if (done_o) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("en_count", en_cnt, e.n);
          check("done_latency", cyc - e.s, e.lat);
          check("en_during_done", int'(en_o), 0);
          check("idle_during_done", int'(idle_o), 0);
        end
        en_cnt = 0;
      end
    end
  end

  task automatic fill_pat(input int pct);
    for (int j = 0; j < 512; j++)
      pat[j] = (j < 300) && ($urandom_range(0, 99) < pct);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the idle
  // cycle following done.
  task automatic run_one(input int n, input bit spur);
    int rem, lat;
    exp_t e;
    rem = n;
    lat = 0;
    while (rem > 0) begin
      if (!pat[lat]) rem--;
      lat++;
    end
    e.n   = n;
    e.lat = lat;
    e.s   = cyc + 1;
    q.push_back(e);
    start_i   = 1'b1;
    num_cnt_i = W'(n);
    stall_i   = 1'b0;
`ifdef CNT_RUN_FSM_ERR_EN
    err_exp = 1'b0;
`endif
    @(posedge clk); #1;
    for (int j = 0; j <= lat; j++) begin
      stall_i   = pat[j];
      start_i   = spur && ($urandom_range(0, 3) == 0);
      num_cnt_i = W'($urandom_range(0, 127));
`ifdef CNT_RUN_FSM_ERR_EN
      if (start_i) err_exp = 1'b1;
`endif
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    stall_i = 1'b0;
    check("idle_after_run", int'(idle_o), 1);
`ifdef CNT_RUN_FSM_ERR_EN
    check("err_after_run", int'(err_o), int'(err_exp));
`endif
  endtask

  initial begin
    #2;
    check("rst_en", int'(en_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_idle", int'(idle_o), 1);
`ifdef CNT_RUN_FSM_ERR_EN
    check("rst_err", int'(err_o), 0);
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill_pat(0);
    run_one(5, 1'b0);

    fill_pat(0);
    pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b1;
    run_one(4, 1'b0);

    fill_pat(0);
    run_one(0, 1'b0);

    fill_pat(0);
    run_one(127, 1'b0);

    fill_pat(0);
    run_one(6, 1'b1);
    run_one(3, 1'b0);

    // Abort a 10-long run after three enables.
    start_i   = 1'b1;
    num_cnt_i = W'(10);
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("en_before_abort", int'(en_o), 1);
    rst_n = 1'b0;
    #1;
    check("abort_en", int'(en_o), 0);
    check("abort_idle", int'(idle_o), 1);
    check("abort_done", int'(done_o), 0);
`ifdef CNT_RUN_FSM_ERR_EN
    check("abort_err", int'(err_o), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
    end
    check("idle_after_abort", int'(idle_o), 1);
    fill_pat(0);
    run_one(2, 1'b0);

    for (int r = 0; r < 30; r++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                      : int'($urandom_range(0, 12));
      fill_pat(int'($urandom_range(0, 40)));
      run_one(n, $urandom_range(0, 1) == 1);
    end

    repeat (4) begin
      @(posedge clk); #1;
    end
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnt_run_fsm.md
# cnt_run_fsm

Control FSM placed directly upstream of the address `Counter`. It accepts a start request with a run length and drives the counter's `en` input for exactly that many enabled cycles. Consumer stalls pause enabling without losing count. It then pulses `done` for one cycle, which clears the counter and tells downstream logic the run has finished.

## Interface
- `CNT_WIDTH`, 7, width of the run-length field; must match the `Counter` instance.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start_i` input 1: run request; sampled only in IDLE.
- `num_cnt_i` input CNT_WIDTH: run length N, the number of enabled cycles; captured with `start_i`.
- `stall_i` input 1: consumer back-pressure; while high in RUN, `en_o` is forced low.
- `en_o` output 1: connects to counter `en`.
- `done_o` output 1: one-cycle pulse; connects to counter `done_i` and downstream.
- `idle_o` output 1: high when in IDLE (ready for `start_i`).
- `err_o` output 1: sticky start-while-busy flag; present only with the macro.

## Operation
- States:
  - IDLE: no enables issued; waits for `start_i`.
  - RUN: issues enables until N have been issued.
  - DONE: emits the `done_o` pulse.
- IDLE and `start_i`=1:
  - capture `num_cnt_i` into `remain_r`.
  - N≠0: go to RUN.
  - N=0: go straight to DONE; no `en_o` is ever asserted.
- RUN:
  - `en_o` = !`stall_i`. This is combinational from state and `stall_i`, so it responds in the same cycle.
  - Each cycle with `en_o`=1 decrements `remain_r`.
  - If `en_o`=1 and `remain_r`=1, next state is DONE.
  - Stall cycles do not decrement `remain_r` and do not change state.
- DONE:
  - `done_o`=1, `en_o`=0, for exactly one cycle.
  - Next state is unconditionally IDLE.
- `start_i` in RUN or DONE is ignored; it is never queued.
- Outputs decoded from state:
  - `idle_o` = (state==IDLE).
  - `done_o` = (state==DONE).
- Arithmetic: `remain_r` is CNT_WIDTH bits and only counts down, so it cannot wrap. Maximum run is 2^CNT_WIDTH−1 enables; the counter then ends at 2^CNT_WIDTH−1 without wrapping.
- Asynchronous reset, including mid-RUN:
  - state returns to IDLE and `remain_r` is cleared to 0.
  - `en_o`=0, `done_o`=0, `idle_o`=1, `err_o`=0.
  - No `done_o` pulse is produced for the aborted run.

## Timing
- Start to first enable:
  - `start_i` sampled at edge k.
  - `en_o` is first high in cycle k+1, unless `stall_i` is high then.
- Run length: with no stalls, `en_o` is high for cycles k+1..k+N, and `done_o` is high in cycle k+N+1.
- Counter interaction:
  - at the edge ending cycle k+N, the counter holds N.
  - at the edge ending the `done_o` cycle, the counter clears to 0.
  - `idle_o` returns high in cycle k+N+2.
- Each stall cycle in RUN delays `done_o` by one cycle.
- N=0: `done_o` is high in cycle k+1 and `idle_o` is high in cycle k+2.
- Back-to-back runs: the minimum start-to-start spacing is N+2 cycles.

## Configuration
- `CNT_RUN_FSM_ERR_EN` defined:
  - `err_o` is set at the edge where `start_i`=1 and state≠IDLE.
  - it stays set until the next accepted start (IDLE & `start_i`) clears it at that edge.
  - reset value 0.
- `CNT_RUN_FSM_ERR_EN` undefined:
  - `err_o` port and its register are absent.
  - behaviour is otherwise identical.

## Structure
- A shared package holds:
  - the state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - the default `CNT_WIDTH`.
- Sub-module `cnt_run_remain`: loadable down-counter with `load`, `dec` and `last` (remain==1) outputs. The FSM itself keeps only the state register and the output decode.

## Test plan
- Reset, then `start_i` with N=5 and no stalls → `en_o` high for exactly 5 consecutive cycles, then a 1-cycle `done_o`; the counter's `cnt_o` peaks at 5 and then reads 0.
- N=4 with `stall_i` high for 3 cycles mid-run → still exactly 4 enable cycles in total; `done_o` arrives 3 cycles later than in the unstalled case.
- N=0 → `done_o` in the cycle after start; `en_o` never high.
- N=127 (`CNT_WIDTH`=7) → 127 enables, counter reaches 127 with no wrap, then `done_o`.
- Assert `rst_n` low during RUN with N=10 after 3 enables → `en_o` drops immediately; `idle_o`=1; no `done_o`; a fresh start with N=2 then works normally.
- With `CNT_RUN_FSM_ERR_EN`: `start_i` pulsed during RUN → `err_o`=1, the current run is unaffected, and the next accepted start clears `err_o`.
